// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, floor width and seven-segment digits
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_e;
  localparam int FLOOR_W = 2;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_OFF = 7'b1111111;
endpackage

// File: rtl/elevator_scheduler_floor_seg_decode.sv
// floor_seg_decode: floor index to active-low abcdefg digit showing floor+1
module floor_seg_decode import elevator_pkg::*; #(
  parameter int W = FLOOR_W
) (
  input  logic [W-1:0] floor_i,
  output logic [0:6]   seg_o
);
  // one-based digit for the four labelled floors, blank otherwise
  always_comb seg_o = floor_i == W'(0) ? SEG_1 :
                      floor_i == W'(1) ? SEG_2 :
                      floor_i == W'(2) ? SEG_3 :
                      floor_i == W'(3) ? SEG_4 : SEG_OFF;
endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN call scheduler with travel/door timing; FLOOR_SEG_EN adds a registered floor digit output
module elevator_scheduler import elevator_pkg::*; #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FLOORS-1:0]         call_req,
  output logic [NUM_FLOORS-1:0]         pending,
  output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
  output logic                          dir_up,
  output logic                          moving,
  output logic                          door_open,
  output logic                          step_up,
  output logic                          step_down
`ifdef FLOOR_SEG_EN
  ,
  output logic [0:6]                    seg
`endif
);
  localparam int FW = $clog2(NUM_FLOORS);
  localparam int CMAX = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);
  state_e                state_q;
  logic [FW-1:0]         floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d, above, below, clear;
  logic [CW-1:0]         cnt_q;
  logic                  dir_q, moving_q, door_q, up_q, down_q;
  logic                  arrive, here, ahead, behind, door_enter, door_restart;
  // floor held after this edge and the SCAN view of outstanding calls from it
  always_comb begin
    arrive = state_q == MOVING && cnt_q == '0;
    floor_d = arrive ? (dir_q ? floor_q + FW'(1) : floor_q - FW'(1)) : floor_q;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above[i] = FW'(i) > floor_d;
      below[i] = FW'(i) < floor_d;
    end
    here = pend_q[floor_d];
    ahead = |(pend_q & (dir_q ? above : below));
    behind = |(pend_q & (dir_q ? below : above));
    door_enter = (state_q == IDLE || arrive) && here;
    door_restart = state_q == DOOR && call_req[floor_q];
    clear = door_enter || door_restart ? NUM_FLOORS'(1) << floor_d : '0;
    pend_d = (pend_q | call_req) & ~clear;
  end
  // call latching, SCAN decisions, travel/door timing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      floor_q <= '0;
      pend_q <= '0;
      dir_q <= 1'b1;
      cnt_q <= '0;
      moving_q <= 1'b0;
      door_q <= 1'b0;
      up_q <= 1'b0;
      down_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      floor_q <= floor_d;
      up_q <= arrive && dir_q;
      down_q <= arrive && !dir_q;
      case (state_q)
        IDLE, MOVING: begin
          if (state_q == MOVING && !arrive) cnt_q <= cnt_q - CW'(1);
          else if (here) begin
            state_q <= DOOR;
            cnt_q <= DOOR_LOAD;
            moving_q <= 1'b0;
            door_q <= 1'b1;
          end else if (ahead || behind) begin
            state_q <= MOVING;
            cnt_q <= TRAVEL_LOAD;
            moving_q <= 1'b1;
            dir_q <= ahead ? dir_q : !dir_q;
          end else begin
            state_q <= IDLE;
            moving_q <= 1'b0;
          end
        end
        default: begin
          if (door_restart) cnt_q <= DOOR_LOAD;
          else if (cnt_q == '0) begin
            state_q <= IDLE;
            door_q <= 1'b0;
          end else cnt_q <= cnt_q - CW'(1);
        end
      endcase
    end
  end
  assign pending = pend_q;
  assign cur_floor = floor_q;
  assign dir_up = dir_q;
  assign moving = moving_q;
  assign door_open = door_q;
  assign step_up = up_q;
  assign step_down = down_q;
`ifdef FLOOR_SEG_EN
  logic [0:6] seg_d, seg_q;
  floor_seg_decode #(.W(FW)) u_seg (.floor_i(floor_d), .seg_o(seg_d));
  // digit follows the floor the car holds after this edge
  always_ff @(posedge clk) seg_q <= rst ? SEG_1 : seg_d;
  assign seg = seg_q;
`endif
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed stimulus, per-cycle check against a phase/time-left model plus literal spot checks
module tb_elevator_scheduler;
  localparam int N = 4, T = 4, D = 3;
  logic clk = 0, rst = 1;
  logic [3:0] call_req = '0;
  logic [3:0] pending;
  logic [1:0] cur_floor;
  logic dir_up, moving, door_open, step_up, step_down;
`ifdef FLOOR_SEG_EN
  logic [0:6] seg;
  logic [0:6] seg_tab [4] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
`endif
  int total = 0, bad = 0, e = 0;
  always #5 clk = ~clk;
  elevator_scheduler #(.NUM_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .pending(pending), .cur_floor(cur_floor),
    .dir_up(dir_up), .moving(moving), .door_open(door_open), .step_up(step_up), .step_down(step_down)
`ifdef FLOOR_SEG_EN
    , .seg(seg)
`endif
  );
  // model: mode 0 idle, 1 travelling, 2 door; m_left = cycles left in the current phase
  bit [3:0] m_pend;
  int m_floor, m_mode, m_left, clr;
  bit m_up, m_su, m_sd;
  task automatic m_decide();
    bit ah, bh;
    ah = 0;
    bh = 0;
    if (m_pend[m_floor]) begin
      m_mode = 2;
      m_left = D;
      clr = m_floor;
    end else begin
      for (int f = 0; f < N; f++)
        if (m_pend[f] && f != m_floor) begin
          if ((f > m_floor) == m_up) ah = 1;
          else bh = 1;
        end
      if (ah || bh) begin
        m_mode = 1;
        m_left = T;
        if (!ah) m_up = !m_up;
      end else m_mode = 0;
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_floor = 0; m_up = 1; m_mode = 0; m_left = 0; m_su = 0; m_sd = 0;
    end else begin
      clr = -1; m_su = 0; m_sd = 0;
      if (m_mode == 0) m_decide();
      else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          if (m_up) begin m_floor++; m_su = 1; end
          else begin m_floor--; m_sd = 1; end
          m_decide();
        end
      end else if (call_req[m_floor]) begin
        m_left = D;
        clr = m_floor;
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
      m_pend = m_pend | call_req;
      if (clr >= 0) m_pend[clr] = 0;
    end
  end
  int q_stops[$];
  int n_down = 0;
  bit prev_door = 0;
  always @(posedge clk) begin
    #1;
    total++;
    if ({pending, cur_floor, dir_up, moving, door_open, step_up, step_down} !==
        {m_pend, 2'(m_floor), m_up, m_mode == 1, m_mode == 2, m_su, m_sd}) begin
      bad++;
      $display("FAIL cycle t=%0t got pend=%b fl=%0d up=%b mv=%b dr=%b su=%b sd=%b want pend=%b fl=%0d up=%b mv=%b dr=%b su=%b sd=%b",
               $time, pending, cur_floor, dir_up, moving, door_open, step_up, step_down,
               m_pend, m_floor, m_up, m_mode == 1, m_mode == 2, m_su, m_sd);
    end
`ifdef FLOOR_SEG_EN
    total++;
    if (seg !== seg_tab[m_floor]) begin
      bad++;
      $display("FAIL seg got=%b want=%b", seg, seg_tab[m_floor]);
    end
`endif
    if (door_open && !prev_door) q_stops.push_back(int'(cur_floor));
    prev_door = door_open;
    if (step_down) n_down++;
  end
  task automatic chk(string name, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask
  task automatic pulse(logic [3:0] v);
    @(negedge clk);
    call_req = v;
    @(posedge clk);
    @(negedge clk);
    call_req = '0;
    e = 1;
  endtask
  task automatic to_edge(int n);
    repeat (n - e) @(posedge clk);
    #1;
    e = n;
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_pend"}, pending, 0);
    chk({tag, "_floor"}, cur_floor, 0);
    chk({tag, "_dir"}, dir_up, 1);
    chk({tag, "_flags"}, {moving, door_open, step_up, step_down}, 0);
  endtask
  initial begin
    int base, nd;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst0");
    @(negedge clk);
    rst = 0;
    // single call to floor 2
    pulse(4'b0100);
    to_edge(5);  chk("t1_e5_floor", cur_floor, 0); chk("t1_e5_su", step_up, 0);
    to_edge(6);  chk("t1_e6_floor", cur_floor, 1); chk("t1_e6_su", step_up, 1);
    to_edge(7);  chk("t1_e7_su", step_up, 0);
    to_edge(10); chk("t1_e10_floor", cur_floor, 2); chk("t1_e10_door", door_open, 1); chk("t1_e10_su", step_up, 1);
    to_edge(12); chk("t1_e12_door", door_open, 1);
    to_edge(13); chk("t1_e13_door", door_open, 0); chk("t1_e13_mv", moving, 0); chk("t1_e13_pend", pending, 0);
    // call at current floor, repeat mid-door extends dwell
    pulse(4'b0100);
    to_edge(2); chk("t2_e2_door", door_open, 1); chk("t2_e2_pend", pending, 0);
    to_edge(3);
    @(negedge clk);
    call_req = 4'b0100;
    to_edge(4); chk("t2_e4_pend", pending, 0);
    @(negedge clk);
    call_req = '0;
    to_edge(5); chk("t2_e5_door", door_open, 1);
    to_edge(6); chk("t2_e6_door", door_open, 1); chk("t2_e6_steps", {step_up, step_down}, 0);
    to_edge(7); chk("t2_e7_door", door_open, 0);
    // move to floor 1, then SCAN: up to 3 with calls at 0 and 2 arriving en route
    pulse(4'b0010);
    to_edge(15); chk("t3_at1", cur_floor, 1); chk("t3_dir_dn", dir_up, 0);
    base = q_stops.size();
    pulse(4'b1000);
    to_edge(2); chk("t3_e2_mv", moving, 1); chk("t3_e2_dir", dir_up, 1);
    @(negedge clk);
    call_req = 4'b0101;
    to_edge(3);
    @(negedge clk);
    call_req = '0;
    to_edge(16); chk("t3_e16_floor", cur_floor, 3); chk("t3_e16_door", door_open, 1); chk("t3_e16_dir", dir_up, 1);
    to_edge(18); chk("t3_e18_dir", dir_up, 0); chk("t3_e18_mv", moving, 1);
    to_edge(40);
    chk("t3_nstops", q_stops.size() - base, 3);
    if (q_stops.size() - base == 3) begin
      chk("t3_stop0", q_stops[base], 2);
      chk("t3_stop1", q_stops[base + 1], 3);
      chk("t3_stop2", q_stops[base + 2], 0);
    end
    chk("t3_end_floor", cur_floor, 0);
    // boundary: from top floor, single call to floor 0
    pulse(4'b1000);
    to_edge(25); chk("t4_at3", cur_floor, 3); chk("t4_dir", dir_up, 1);
    nd = n_down;
    pulse(4'b0001);
    to_edge(2);  chk("t4_e2_dir", dir_up, 0); chk("t4_e2_mv", moving, 1); chk("t4_e2_floor", cur_floor, 3);
    to_edge(6);  chk("t4_e6_sd", step_down, 1); chk("t4_e6_floor", cur_floor, 2);
    to_edge(30); chk("t4_floor", cur_floor, 0); chk("t4_ndown", n_down - nd, 3); chk("t4_idle", {moving, door_open}, 0);
    // reset mid-travel discards calls
    pulse(4'b1100);
    to_edge(4); chk("t5_mv", moving, 1);
    @(negedge clk);
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst1");
    @(negedge clk);
    rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk_reset("rst1_after");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
